// File: rtl/srt_quotient_resolve.sv
// Quotient resolve stage for the radix-4 SRT divider: on-the-fly digit conversion, residual
// sign resolve, -1 ulp correction and sticky. Optional digit counter: FP_DIV_DIGIT_COUNT_CHECK_EN.
package fpu_types;
    typedef enum logic [2:0] {
        NEG_TWO = 3'b110,
        NEG_ONE = 3'b111,
        ZERO    = 3'b000,
        POS_ONE = 3'b001,
        POS_TWO = 3'b010
    } q_t;
endpackage

module srt_quotient_resolve
    import fpu_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  digit_valid,
    input  q_t                    q_digit,
    input  logic                  last_digit,
    input  logic [WIDTH-3:0]      wsum,
    input  logic [WIDTH-3:0]      wcarry,
    input  logic [WIDTH-4:0]      divisor,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [2*DIGITS-1:0]   quotient,
    output logic                  remainder_nonzero,
    output logic                  digit_count_error
);

    localparam int QW = 2 * DIGITS;
    localparam int RW = WIDTH - 2;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t          state;
    logic [QW-1:0]   q_acc, qm_acc;
    logic [RW-1:0]   r_sum, r_carry;

    logic [2:0]      q_bits;
    logic            digit_neg, digit_pos;
    logic [1:0]      d_lo, dm_lo;
    logic [QW-1:0]   q_next, qm_next;
    logic [RW-1:0]   r_full, r_adj;
    logic            accept;

    assign accept = (state == ACCUM) && digit_valid;

    // The low two bits of q (mod 4) equal 4+q for negative digits, and q-1 (mod 4) equals
    // 3+q, so both accumulators append a fixed pattern and only the source register varies.
    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        q_bits    = q_digit;
        digit_neg = q_bits[2];
        digit_pos = !q_bits[2] && (q_bits[1:0] != 2'b00);
        d_lo      = q_bits[1:0];
        dm_lo     = q_bits[1:0] - 2'd1;
        q_next    = {(digit_neg ? qm_acc[QW-3:0] : q_acc[QW-3:0]), d_lo};
        qm_next   = {(digit_pos ? q_acc[QW-3:0]  : qm_acc[QW-3:0]), dm_lo};
        r_full    = r_sum + r_carry;
        r_adj     = r_full + {1'b0, divisor};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            q_acc             <= '0;
            qm_acc            <= '1;
            r_sum             <= '0;
            r_carry           <= '0;
            busy              <= 1'b0;
            result_valid      <= 1'b0;
            quotient          <= '0;
            remainder_nonzero <= 1'b0;
        end else if (start) begin
            state        <= ACCUM;
            q_acc        <= '0;
            qm_acc       <= '1;
            busy         <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ACCUM: begin
                    if (digit_valid) begin
                        q_acc  <= q_next;
                        qm_acc <= qm_next;
                        if (last_digit) begin
                            r_sum   <= wsum;
                            r_carry <= wcarry;
                            state   <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    // A negative residual means the last digit overshot: take QM (Q - 1 ulp).
                    quotient          <= r_full[RW-1] ? qm_acc : q_acc;
                    remainder_nonzero <= r_full[RW-1] ? (r_adj != '0) : (r_full != '0);
                    result_valid      <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_DIV_DIGIT_COUNT_CHECK_EN
    // One spare code above DIGITS so the counter can saturate at DIGITS+1.
    localparam int CW = $clog2(DIGITS + 2);
    logic [CW-1:0] digit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_cnt         <= '0;
            digit_count_error <= 1'b0;
        end else if (start) begin
            digit_cnt         <= '0;
            digit_count_error <= 1'b0;
        end else if (accept) begin
            if (digit_cnt != CW'(DIGITS + 1))
                digit_cnt <= digit_cnt + 1'b1;
            if (last_digit)
                digit_count_error <= (({1'b0, digit_cnt} + (CW+1)'(1)) != (CW+1)'(DIGITS));
        end
    end
`else
    logic unused_accept;
    assign unused_accept     = accept;
    assign digit_count_error = 1'b0;
`endif

endmodule

// File: tb/tb_srt_quotient_resolve.sv
// Scoreboard bench for srt_quotient_resolve (DIGITS=3): directed divisions with hand-computed
// quotients, backpressure, abort, async reset and the optional digit-count flag.
module tb_srt_quotient_resolve;
    import fpu_types::*;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 3;
    localparam int QW     = 2 * DIGITS;
    localparam int RW     = WIDTH - 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            digit_valid = 1'b0;
    q_t              q_digit = ZERO;
    logic            last_digit = 1'b0;
    logic [RW-1:0]   wsum = '0;
    logic [RW-1:0]   wcarry = '0;
    logic [RW-2:0]   divisor = '0;
    logic            busy;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [QW-1:0]   quotient;
    logic            remainder_nonzero;
    logic            digit_count_error;

    srt_quotient_resolve #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .digit_valid       (digit_valid),
        .q_digit           (q_digit),
        .last_digit        (last_digit),
        .wsum              (wsum),
        .wcarry            (wcarry),
        .divisor           (divisor),
        .busy              (busy),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .quotient          (quotient),
        .remainder_nonzero (remainder_nonzero),
        .digit_count_error (digit_count_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [QW-1:0] q;
        logic          sticky;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef FP_DIV_DIGIT_COUNT_CHECK_EN
    localparam logic SHORT_ERR = 1'b1;
`else
    localparam logic SHORT_ERR = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares each result at the handshake, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_quotient", quotient, e.q);
                    check("mon_sticky", remainder_nonzero, e.sticky);
                    check("mon_count_err", digit_count_error, e.err);
                end
            end
        end
    end

    // Issue a division of n digits; last_digit goes with digit n-1.
    task automatic run_div(input int digs[3], input int n, input logic [RW-1:0] ws,
                           input logic [RW-1:0] wc, input logic [RW-2:0] d,
                           input logic [QW-1:0] eq, input logic es, input logic ee,
                           input int hold);
        int dv;
        divisor = d;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            dv          = digs[i];
            digit_valid = 1'b1;
            q_digit     = q_t'(dv[2:0]);
            last_digit  = (i == n - 1);
            wsum        = (i == n - 1) ? ws : '1;
            wcarry      = (i == n - 1) ? wc : '1;
            tick();
        end
        sb.push_back('{q: eq, sticky: es, err: ee});
        digit_valid = 1'b0;
        last_digit  = 1'b0;
        wsum        = '0;
        wcarry      = '0;
        check("lat_resolve_not_valid", result_valid, 0);
        tick();
        check("lat_valid", result_valid, 1);
        check("busy_done", busy, 1);
        for (int k = 0; k < hold; k++) begin
            check("hold_quotient", quotient, eq);
            check("hold_valid", result_valid, 1);
            check("hold_busy", busy, 1);
            tick();
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("post_hs_valid", result_valid, 0);
        check("post_hs_idle", busy, 0);
    endtask

    int d_main[3]  = '{1, -2, 2};
    int d_short[3] = '{1, -2, 0};
    int d_abort[3] = '{-1, 0, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_sticky", remainder_nonzero, 0);
        check("rst_count_err", digit_count_error, 0);
        rst = 1'b0;
        tick();

        // Digits and ready outside ACCUM/DONE are ignored.
        digit_valid  = 1'b1;
        last_digit   = 1'b1;
        result_ready = 1'b1;
        tick();
        tick();
        digit_valid  = 1'b0;
        last_digit   = 1'b0;
        result_ready = 1'b0;
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_valid", result_valid, 0);

        // +1,-2,+2: Q=001010, QM=001001
        run_div(d_main, 3, 30'd5, 30'd0, 29'h1000_0000, 6'b001010, 1'b1, 1'b0, 5);
        run_div(d_main, 3, 30'h3FFF_FFFF, 30'd0, 29'h1000_0000, 6'b001001, 1'b1, 1'b0, 0);
        run_div(d_main, 3, 30'h3000_0000, 30'd0, 29'h1000_0000, 6'b001001, 1'b0, 1'b0, 1);
        run_div(d_main, 3, 30'd0, 30'd0, 29'h1000_0000, 6'b001010, 1'b0, 1'b0, 0);
        run_div(d_main, 3, 30'd3, 30'h3FFF_FFFE, 29'h1000_0000, 6'b001010, 1'b1, 1'b0, 0);

        // Short run: last_digit on the 2nd digit -> Q=000010.
        run_div(d_short, 2, 30'd0, 30'd0, 29'h1000_0000, 6'b000010, 1'b0, SHORT_ERR, 0);

        // Abort after two digits; the restart cycle carries a digit that must be ignored.
        start = 1'b1;
        tick();
        start       = 1'b0;
        digit_valid = 1'b1;
        q_digit     = POS_TWO;
        tick();
        tick();
        check("abort_busy", busy, 1);
        // -1,0,+1 = -15 -> 110001
        run_div(d_abort, 3, 30'd0, 30'd0, 29'h1000_0000, 6'b110001, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of ACCUM.
        start = 1'b1;
        tick();
        start       = 1'b0;
        digit_valid = 1'b1;
        q_digit     = NEG_ONE;
        tick();
        tick();
        digit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_sticky", remainder_nonzero, 0);
        check("mid_rst_count_err", digit_count_error, 0);
        tick();
        rst = 1'b0;
        tick();
        run_div(d_main, 3, 30'd0, 30'd0, 29'h1000_0000, 6'b001010, 1'b0, 1'b0, 0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
